// File: rtl/arbitro_jogadores.sv
// Round-robin turn arbiter for multiplayer rounds: grants, answer timing, lockouts, round end.
// Optional FALSA_LARGADA_EN: buttons held at round open lock those players out for the round.
module arbitro_jogadores #(
  parameter int N_JOGADORES = 4,
  parameter int LARGURA_ID  = 2,
  parameter int T_RESPOSTA  = 5000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   abre_rodada,
  input  logic [N_JOGADORES-1:0] botoes,
  input  logic                   resultado_valido,
  input  logic                   resultado_correto,
  output logic                   concedido,
  output logic [LARGURA_ID-1:0]  jogador,
  output logic [N_JOGADORES-1:0] vez,
  output logic [N_JOGADORES-1:0] bloqueados,
  output logic                   timeout_resposta,
  output logic                   rodada_encerrada,
  output logic                   vencedor_valido,
  output logic [3:0]             db_estado
);

  localparam int LT = $clog2(T_RESPOSTA);
  localparam logic [N_JOGADORES-1:0] TODOS = '1;

  typedef enum logic [3:0] {
    OCIOSO      = 4'h0,
    ARMADO      = 4'h1,
    RESPONDENDO = 4'h2,
    ENCERRADA   = 4'hF
  } estado_t;

  estado_t                estado;
  logic [LARGURA_ID-1:0]  ptr;
  logic [LT-1:0]          timer;

  function automatic logic [N_JOGADORES-1:0] onehot(input logic [LARGURA_ID-1:0] k);
    return {{(N_JOGADORES-1){1'b0}}, 1'b1} << k;
  endfunction

  // First requester found scanning ptr, ptr+1, ... with wrap at N_JOGADORES.
  function automatic logic [LARGURA_ID-1:0] escolhe(input logic [N_JOGADORES-1:0] req_in,
                                                    input logic [LARGURA_ID-1:0] p);
    logic                  achou;
    logic [LARGURA_ID-1:0] r;
    int                    idx;
    achou = 1'b0;
    r     = '0;
    for (int i = 0; i < N_JOGADORES; i++) begin
      idx = (int'(p) + i) % N_JOGADORES;
      if (!achou && req_in[idx]) begin
        achou = 1'b1;
        r     = LARGURA_ID'(idx);
      end
    end
    return r;
  endfunction

  logic [N_JOGADORES-1:0] req;
  logic [LARGURA_ID-1:0]  escolhido;
  logic [LARGURA_ID-1:0]  ptr_prox;
  logic [N_JOGADORES-1:0] bloq_erro;
  logic                   expirou;

  assign req       = botoes & ~bloqueados;
  assign escolhido = escolhe(req, ptr);
  assign ptr_prox  = LARGURA_ID'((int'(escolhido) + 1) % N_JOGADORES);
  assign bloq_erro = bloqueados | onehot(jogador);
  assign expirou   = (timer == LT'(T_RESPOSTA - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado           <= OCIOSO;
      concedido        <= 1'b0;
      jogador          <= '0;
      vez              <= '0;
      bloqueados       <= '0;
      timeout_resposta <= 1'b0;
      rodada_encerrada <= 1'b0;
      vencedor_valido  <= 1'b0;
      ptr              <= '0;
      timer            <= '0;
    end else begin
      timeout_resposta <= 1'b0;
      if (abre_rodada) begin
        timer           <= '0;
        concedido       <= 1'b0;
        vez             <= '0;
        vencedor_valido <= 1'b0;
`ifdef FALSA_LARGADA_EN
        bloqueados <= botoes;
        if (botoes == TODOS) begin
          estado           <= ENCERRADA;
          rodada_encerrada <= 1'b1;
        end else begin
          estado           <= ARMADO;
          rodada_encerrada <= 1'b0;
        end
`else
        bloqueados       <= '0;
        estado           <= ARMADO;
        rodada_encerrada <= 1'b0;
`endif
      end else begin
        case (estado)
          OCIOSO: ;
          ARMADO: begin
            if (req != '0) begin
              estado    <= RESPONDENDO;
              concedido <= 1'b1;
              jogador   <= escolhido;
              vez       <= onehot(escolhido);
              timer     <= '0;
              ptr       <= ptr_prox;
            end
          end
          RESPONDENDO: begin
            timer <= timer + 1'b1;
            if (resultado_valido && resultado_correto) begin
              estado           <= ENCERRADA;
              vencedor_valido  <= 1'b1;
              rodada_encerrada <= 1'b1;
              concedido        <= 1'b0;
              vez              <= '0;
            end else if (resultado_valido || expirou) begin
              // A judged answer on the expiry cycle suppresses the timeout pulse.
              timeout_resposta <= !resultado_valido;
              bloqueados       <= bloq_erro;
              concedido        <= 1'b0;
              vez              <= '0;
              if (bloq_erro == TODOS) begin
                estado           <= ENCERRADA;
                rodada_encerrada <= 1'b1;
              end else begin
                estado <= ARMADO;
              end
            end
          end
          ENCERRADA: ;
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

  always_comb begin
    case (estado)
      OCIOSO, ARMADO, RESPONDENDO, ENCERRADA: db_estado = estado;
      default:                                db_estado = 4'hB;
    endcase
  end

endmodule
